// File: rtl/sdrc_init_pkg.sv
// rtl/sdrc_init_pkg.sv - shared types and constants for the SDRAM init sequencer
package sdrc_init_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_PRE,
    ST_TRP,
    ST_AR,
    ST_TRFC,
    ST_MRS,
    ST_TMRD,
    ST_DONE
  } init_state_t;

  // {cs_n, ras_n, cas_n, we_n}
  typedef logic [3:0] sdr_cmd_t;

  localparam sdr_cmd_t CMD_NOP = 4'b0111;
  localparam sdr_cmd_t CMD_PRE = 4'b0010;
  localparam sdr_cmd_t CMD_AR  = 4'b0001;
  localparam sdr_cmd_t CMD_MRS = 4'b0000;

  // A10 high selects all banks for precharge
  localparam logic [12:0] PRE_ALL_ADDR = 13'h0400;

  // Wait timer must hold both the power-up count and any 4-bit timing config
  function automatic int timer_width(input int cycles);
    int w;
    w = $clog2(cycles + 1);
    return (w < 4) ? 4 : w;
  endfunction

endpackage

// File: rtl/sdrc_init_timer.sv
// rtl/sdrc_init_timer.sv - loadable down-counter shared by all init wait states
module sdrc_init_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] r_count;

  // Load clamps zero to one so every wait lasts at least a cycle; otherwise count down to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= (load_val == '0) ? W'(1) : load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  // Last cycle of the wait: the owning FSM leaves its state on this edge
  assign expire = (r_count == W'(1));

endmodule

// File: rtl/sdrc_init_seq.sv
// rtl/sdrc_init_seq.sv - SDRAM power-up init sequencer (NOP, PRE-all, N x AR, MRS)
module sdrc_init_seq
  import sdrc_init_pkg::*;
#(
  parameter int PWRUP_CYCLES = 505,
  parameter int AR_CNT_W     = 4
) (
  input  logic                sdram_clk,
  input  logic                sdram_resetn,
  input  logic                cfg_sdr_en,
  input  logic [12:0]         cfg_sdr_mode_reg,
  input  logic [3:0]          cfg_sdr_trp_d,
  input  logic [3:0]          cfg_sdr_trcar_d,
  input  logic [3:0]          cfg_sdr_tmrd_d,
  input  logic [AR_CNT_W-1:0] cfg_sdr_ar_cnt,
  output logic                sdr_cke,
  output logic                sdr_cs_n,
  output logic                sdr_ras_n,
  output logic                sdr_cas_n,
  output logic                sdr_we_n,
  output logic [12:0]         sdr_addr,
  output logic [1:0]          sdr_ba,
  output logic                sdr_init_done,
  output logic                init_busy
);

  localparam int TW = timer_width(PWRUP_CYCLES);

  init_state_t         r_state;

  // Config shadows captured when the sequence starts
  logic [12:0]         r_mode_reg;
  logic [3:0]          r_trp_d;
  logic [3:0]          r_trcar_d;
  logic [3:0]          r_tmrd_d;
  logic [AR_CNT_W-1:0] r_ar_rem;

  // Registered bus outputs
  logic                r_cke;
  sdr_cmd_t            r_cmd;
  logic [12:0]         r_addr;
  logic [1:0]          r_ba;
  logic                r_init_done;
  logic                r_init_busy;

  logic                w_load;
  logic [TW-1:0]       w_load_val;
  logic                w_expire;

  // Timer is reloaded in the state just before each wait state
  always_comb begin
    w_load     = 1'b0;
    w_load_val = '0;
    case (r_state)
      ST_IDLE: begin
        w_load     = 1'b1;
        w_load_val = TW'(PWRUP_CYCLES);
      end
      ST_PRE: begin
        w_load     = 1'b1;
        w_load_val = TW'(r_trp_d);
      end
      ST_AR: begin
        w_load     = 1'b1;
        w_load_val = TW'(r_trcar_d);
      end
      ST_MRS: begin
        w_load     = 1'b1;
        w_load_val = TW'(r_tmrd_d);
      end
      default: begin
        w_load     = 1'b0;
        w_load_val = '0;
      end
    endcase
  end

  sdrc_init_timer #(
    .W (TW)
  ) u_timer (
    .clk      (sdram_clk),
    .rst_n    (sdram_resetn),
    .load     (w_load),
    .load_val (w_load_val),
    .expire   (w_expire)
  );

  // Init FSM: outputs are registered from the current state, so each command lands one cycle after entry
  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      r_state     <= ST_IDLE;
      r_mode_reg  <= '0;
      r_trp_d     <= '0;
      r_trcar_d   <= '0;
      r_tmrd_d    <= '0;
      r_ar_rem    <= '0;
      r_cke       <= 1'b0;
      r_cmd       <= 4'b1111;
      r_addr      <= '0;
      r_ba        <= '0;
      r_init_done <= 1'b0;
      r_init_busy <= 1'b0;
    end else begin
      r_cke       <= (r_state != ST_IDLE);
      r_cmd       <= CMD_NOP;
      r_addr      <= '0;
      r_ba        <= '0;
      r_init_done <= (r_state == ST_DONE);
      r_init_busy <= (r_state != ST_IDLE) && (r_state != ST_DONE);

      case (r_state)
        ST_PRE: begin
          r_cmd  <= CMD_PRE;
          r_addr <= PRE_ALL_ADDR;
        end
        ST_AR: begin
          r_cmd <= CMD_AR;
        end
        ST_MRS: begin
          r_cmd  <= CMD_MRS;
          r_addr <= r_mode_reg;
        end
        default: begin
          r_cmd <= CMD_NOP;
        end
      endcase

      case (r_state)
        ST_IDLE: begin
          if (cfg_sdr_en) begin
            r_mode_reg <= cfg_sdr_mode_reg;
            r_trp_d    <= cfg_sdr_trp_d;
            r_trcar_d  <= cfg_sdr_trcar_d;
            r_tmrd_d   <= cfg_sdr_tmrd_d;
            // A zero refresh count still issues one AR
            r_ar_rem   <= (cfg_sdr_ar_cnt == '0) ? AR_CNT_W'(1) : cfg_sdr_ar_cnt;
            r_state    <= ST_PWRUP;
          end
        end
        ST_PWRUP: begin
          if (w_expire) begin
            r_state <= ST_PRE;
          end
        end
        ST_PRE: begin
          r_state <= ST_TRP;
        end
        ST_TRP: begin
          if (w_expire) begin
            r_state <= ST_AR;
          end
        end
        ST_AR: begin
          if (r_ar_rem != '0) begin
            r_ar_rem <= r_ar_rem - AR_CNT_W'(1);
          end
          r_state <= ST_TRFC;
        end
        ST_TRFC: begin
          if (w_expire) begin
            r_state <= (r_ar_rem != '0) ? ST_AR : ST_MRS;
          end
        end
        ST_MRS: begin
          r_state <= ST_TMRD;
        end
        ST_TMRD: begin
          if (w_expire) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign sdr_cke = r_cke;
  assign {sdr_cs_n, sdr_ras_n, sdr_cas_n, sdr_we_n} = r_cmd;
  assign sdr_addr      = r_addr;
  assign sdr_ba        = r_ba;
  assign sdr_init_done = r_init_done;
  assign init_busy     = r_init_busy;

endmodule

// File: tb/tb_sdrc_init_seq.sv
// tb/tb_sdrc_init_seq.sv - self-checking bench for sdrc_init_seq
module tb_sdrc_init_seq;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [12:0] mode = '0;
  logic [3:0]  trp = '0;
  logic [3:0]  trcar = '0;
  logic [3:0]  tmrd = '0;
  logic [3:0]  arc = '0;

  logic        cke, cs_n, ras_n, cas_n, we_n, done, busy;
  logic [12:0] addr;
  logic [1:0]  ba;

  int checks = 0;
  int errors = 0;

  localparam logic [21:0] RESET_VEC = {1'b0, 4'b1111, 13'h0, 2'b00, 1'b0, 1'b0};

  sdrc_init_seq #(
    .PWRUP_CYCLES (P),
    .AR_CNT_W     (4)
  ) dut (
    .sdram_clk        (clk),
    .sdram_resetn     (rst_n),
    .cfg_sdr_en       (en),
    .cfg_sdr_mode_reg (mode),
    .cfg_sdr_trp_d    (trp),
    .cfg_sdr_trcar_d  (trcar),
    .cfg_sdr_tmrd_d   (tmrd),
    .cfg_sdr_ar_cnt   (arc),
    .sdr_cke          (cke),
    .sdr_cs_n         (cs_n),
    .sdr_ras_n        (ras_n),
    .sdr_cas_n        (cas_n),
    .sdr_we_n         (we_n),
    .sdr_addr         (addr),
    .sdr_ba           (ba),
    .sdr_init_done    (done),
    .init_busy        (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] observed();
    return {cke, cs_n, ras_n, cas_n, we_n, addr, ba, done, busy};
  endfunction

  // Cycle on which init_done first reads 1, from the published schedule
  function automatic int done_cycle(input int t, input int r, input int m, input int n);
    int te, re, me, ne, ar0, mrs;
    te  = (t == 0) ? 1 : t;
    re  = (r == 0) ? 1 : r;
    me  = (m == 0) ? 1 : m;
    ne  = (n == 0) ? 1 : n;
    ar0 = P + 2 + te;
    mrs = ar0 + (ne - 1) * (re + 1) + re + 1;
    return mrs + me + 1;
  endfunction

  // Expected bus for cycle k, where cycle 0 follows the edge that samples en high
  function automatic logic [21:0] model(input int k, input int t, input int r, input int m,
                                        input int n, input logic [12:0] mr);
    int te, re, ne, ar0, mrs, dn;
    logic [3:0]  cmd;
    logic [12:0] a;
    te  = (t == 0) ? 1 : t;
    re  = (r == 0) ? 1 : r;
    ne  = (n == 0) ? 1 : n;
    ar0 = P + 2 + te;
    mrs = ar0 + (ne - 1) * (re + 1) + re + 1;
    dn  = done_cycle(t, r, m, n);
    cmd = 4'b0111;
    a   = '0;
    if (k == P + 1) begin
      cmd = 4'b0010;
      a   = 13'h0400;
    end else if (k >= ar0 && k < mrs && ((k - ar0) % (re + 1)) == 0) begin
      cmd = 4'b0001;
    end else if (k == mrs) begin
      cmd = 4'b0000;
      a   = mr;
    end
    return {(k >= 1), cmd, a, 2'b00, (k >= dn), (k >= 1 && k < dn)};
  endfunction

  // Reset, start with the given config and compare every cycle against the model.
  // perturb: 0 none, 1 change mode/trcar at cycle 5, 2 randomise en and all cfg each cycle.
  // rst_at >= 0 asserts reset during that cycle and checks the asynchronous clear.
  task automatic run_schedule(input int t, input int r, input int m, input int n,
                              input logic [12:0] mr, input int perturb,
                              input int rst_at, input int tail, input string tag);
    int dn;
    logic [21:0] exp_v, obs_v;
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mode  = mr;
    trp   = 4'(t);
    trcar = 4'(r);
    tmrd  = 4'(m);
    arc   = 4'(n);
    @(negedge clk);
    en = 1'b1;
    dn = done_cycle(t, r, m, n);
    for (int k = 0; k <= dn + tail; k++) begin
      @(negedge clk);
      exp_v = model(k, t, r, m, n, mr);
      obs_v = observed();
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, k, obs_v, exp_v);
      end
      if (k == rst_at) begin
        #1 rst_n = 1'b0;
        #1;
        obs_v = observed();
        checks++;
        if (obs_v !== RESET_VEC) begin
          errors++;
          $display("FAIL %s async reset at cycle %0d: got %h expected %h", tag, k, obs_v, RESET_VEC);
        end
        return;
      end
      if (perturb == 1 && k == 5) begin
        mode  = mr ^ 13'h1fff;
        trcar = 4'(r + 3);
      end else if (perturb == 2) begin
        en    = 1'($urandom_range(0, 1));
        mode  = 13'($urandom);
        trp   = 4'($urandom);
        trcar = 4'($urandom);
        tmrd  = 4'($urandom);
        arc   = 4'($urandom);
      end
    end
  endtask

  task automatic test_reset();
    logic [21:0] obs_v;
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 13'h033;
    trp   = 4'd2;
    trcar = 4'd4;
    tmrd  = 4'd2;
    arc   = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      obs_v = observed();
      checks++;
      if (obs_v !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs_v, RESET_VEC);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({cke, cs_n, ras_n, cas_n, we_n, busy} !== 6'b0_0111_0) begin
      errors++;
      $display("FAIL reset_release_first: got %b expected %b",
               {cke, cs_n, ras_n, cas_n, we_n, busy}, 6'b0_0111_0);
    end
    @(negedge clk);
    checks++;
    if ({cke, busy, done} !== 3'b110) begin
      errors++;
      $display("FAIL reset_release_second: got %b expected %b", {cke, busy, done}, 3'b110);
    end
  endtask

  task automatic test_directed();
    run_schedule(2, 4, 2, 2, 13'h033, 0, -1, 3, "directed");
  endtask

  task automatic test_ar_zero();
    run_schedule(0, 4, 2, 0, 13'h033, 0, -1, 3, "ar_zero");
  endtask

  task automatic test_mid_reset();
    run_schedule(2, 4, 2, 2, 13'h033, 0, 14, 0, "mid_reset");
    @(negedge clk);
    checks++;
    if (observed() !== RESET_VEC) begin
      errors++;
      $display("FAIL mid_reset_hold: got %h expected %h", observed(), RESET_VEC);
    end
    run_schedule(2, 4, 2, 2, 13'h033, 0, -1, 3, "mid_reset_rerun");
  endtask

  task automatic test_cfg_change();
    run_schedule(2, 4, 2, 2, 13'h033, 1, -1, 3, "cfg_change");
  endtask

  task automatic test_after_done();
    run_schedule(2, 4, 2, 2, 13'h033, 2, -1, 100, "after_done");
  endtask

  task automatic test_random();
    int t, r, m, n;
    logic [12:0] mr;
    for (int i = 0; i < 6; i++) begin
      t  = $urandom_range(0, 15);
      r  = $urandom_range(0, 15);
      m  = $urandom_range(0, 15);
      n  = $urandom_range(0, 15);
      mr = 13'($urandom);
      run_schedule(t, r, m, n, mr, 2, -1, 4, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ar_zero();
    test_mid_reset();
    test_cfg_change();
    test_after_done();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdrc_init_seq.md
# sdrc_init_seq

SDRAM power-up initialization sequencer inside `sdrc_core`. After the controller is enabled it drives the SDRAM command bus through the JEDEC init order: power-up NOP, precharge-all, N auto-refreshes, load-mode-register. It then asserts `sdr_init_done` and hands the bus to the normal `xfr_ctl` path. All outputs are registered, so the command mux downstream sees glitch-free command encodings.

## Interface
- `PWRUP_CYCLES`, default 505: number of NOP cycles issued with CKE high before precharge.
- `AR_CNT_W`, default 4: width of the auto-refresh count config.
- `sdram_clk` input 1: SDRAM-domain clock; all logic on its rising edge.
- `sdram_resetn` input 1: reset, asynchronous assert, active-low.
- `cfg_sdr_en` input 1: start request; sampled only in IDLE.
- `cfg_sdr_mode_reg` input 13: value driven on `sdr_addr` during MRS.
- `cfg_sdr_trp_d` input 4: NOP cycles after PRE.
- `cfg_sdr_trcar_d` input 4: NOP cycles after each AR (tRFC).
- `cfg_sdr_tmrd_d` input 4: NOP cycles after MRS.
- `cfg_sdr_ar_cnt` input AR_CNT_W: number of AR commands.
- `sdr_cke` output 1: clock enable.
- `sdr_cs_n`, `sdr_ras_n`, `sdr_cas_n`, `sdr_we_n` output 1 each: command.
- `sdr_addr` output 13: address bus.
- `sdr_ba` output 2: bank address.
- `sdr_init_done` output 1: sticky init-complete flag.
- `init_busy` output 1: high from leaving IDLE until DONE.

## Operation
- States: IDLE, PWRUP, PRE, TRP, AR, TRFC, MRS, TMRD, DONE.
- Command encodings {cs_n,ras_n,cas_n,we_n}: NOP 0111, PRE 0010, AR 0001, MRS 0000.
- IDLE: drives NOP with CKE low. When `cfg_sdr_en`=1:
  - latch all cfg inputs into shadow registers;
  - go to PWRUP.
- Config changes after the latch are ignored until the next reset.
- PWRUP: NOP with CKE=1 for exactly PWRUP_CYCLES cycles, then PRE.
- PRE: one cycle; `sdr_addr[10]`=1, other addr bits 0, ba=0. Then TRP.
- TRP: NOP for max(trp_d,1) cycles, then AR.
- AR: one cycle; decrement the remaining-refresh counter. Then TRFC.
- TRFC: NOP for max(trcar_d,1) cycles.
  - If remaining > 0, go to AR.
  - Otherwise go to MRS.
- `ar_cnt`=0 is treated as 1. Refresh counter is AR_CNT_W bits and never wraps.
- MRS: one cycle; addr=latched mode_reg, ba=0. Then TMRD.
- TMRD: NOP for max(tmrd_d,1) cycles, then DONE.
- DONE: NOP, CKE=1, `sdr_init_done`=1, terminal until reset.
- Every cycle not in PRE, AR or MRS drives NOP, with addr and ba at 0.

## Timing
- Reset values:
  - CKE=0; cs_n, ras_n, cas_n, we_n = 1;
  - addr=0; ba=0;
  - init_done=0; init_busy=0;
  - state IDLE; all counters 0.
- Reset mid-sequence forces reset values within the same cycle (asynchronous). The sequence restarts from IDLE.
- Outputs are registered: a state's command appears on the cycle after entering that state's decision edge.
- Cycle numbering: `cfg_sdr_en` is sampled high on edge 0.
- Schedule with timing config t,r,m and refresh count n:
  - PWRUP NOP: cycles 1..P;
  - PRE: cycle P+1;
  - first AR: cycle P+2+t;
  - each subsequent AR: r+1 cycles later;
  - MRS: last AR + r + 1;
  - init_done rises: MRS + m + 1.
- `init_busy` is high from cycle 1 through the cycle before init_done rises.
- `cfg_sdr_en` toggling after cycle 0 has no effect.

## Structure
- Package `sdrc_init_pkg`:
  - state enum `init_state_t`;
  - command typedef `sdr_cmd_t` (4 bits);
  - constants CMD_NOP, CMD_PRE, CMD_AR, CMD_MRS.
- Sub-module `sdrc_init_timer`:
  - loadable down-counter of width $clog2(PWRUP_CYCLES+1);
  - ports `load`, `load_val`, `expire`.
  - Shared for PWRUP, TRP, TRFC and TMRD waits; min-1 clamping is applied at load.

## Test plan
- PWRUP_CYCLES=8, trp=2, trcar=4, tmrd=2, ar_cnt=2, mode=0x033, en at edge 0 -> PRE@9 with addr[10]=1, AR@12 and AR@17, MRS@22 with addr=0x033, init_done rises @25, NOP on all other cycles.
- Same config with ar_cnt=0 and trp=0 -> PRE@9, single AR@11, MRS@16.
- Reset and hold `sdramresetn` low, en=1 -> all outputs at reset values; CKE=0 until the cycle after release.
- Assert reset at cycle 14 (during TRFC), release, re-enable -> full sequence repeats from PWRUP with identical cycle offsets.
- Change mode_reg and trcar_d at cycle 5 -> MRS still drives the latched 0x033, and spacing is unchanged.
- After init_done, toggle `cfg_sdr_en` for 100 cycles -> init_done stays 1, command stays NOP, init_busy stays 0.
